serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 146 ++++++++++++++
 tb/tb_serial_subtractor.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B, LSB first, one bit per clock.
// A single full-subtractor cell with a registered borrow walks across the
// latched operands; the finished result is published in DONE and held
// until the consumer accepts it.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Operand shift registers, partial result and the serial borrow
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [WIDTH-1:0] res_q;
    logic             borrow_q;
    logic [CNT_W-1:0] cnt_q;
    logic             a_msb_q;
    logic             b_msb_q;

    // Published result registers
    logic             out_valid_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             ovf_q;
    logic             zero_q;

    // Full-subtractor cell on the current LSBs
    logic x_bit, y_bit, d_bit, borrow_nx;
    assign x_bit     = sa_q[0];
    assign y_bit     = sb_q[0];
    assign d_bit     = x_bit ^ y_bit ^ borrow_q;
    assign borrow_nx = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & borrow_q);

    // Control events
    logic accept, last_bit, publish, release_res;
    assign accept      = in_valid && in_ready;
    assign last_bit    = (state_q == SHIFT) && (cnt_q == LAST_BIT);
    // First DONE cycle: the result is registered onto the outputs
    assign publish     = (state_q == DONE) && !out_valid_q;
    assign release_res = out_valid_q && out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)      state_d = SHIFT;
            SHIFT:   if (last_bit)    state_d = DONE;
            DONE:    if (release_res) state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // Output decode: operands are only taken while idle
    always_comb begin
        in_ready = (state_q == IDLE);
    end

    // Serial datapath: latch operands, then one bit per SHIFT cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sa_q     <= '0;
            sb_q     <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
        end else if (accept) begin
            sa_q     <= a;
            sb_q     <= b;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else if (state_q == SHIFT) begin
            sa_q     <= sa_q >> 1;
            sb_q     <= sb_q >> 1;
            // Right shift so bit i lands at res_q[i] after WIDTH cycles
            res_q    <= {d_bit, res_q[WIDTH-1:1]};
            borrow_q <= borrow_nx;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (last_bit) begin
                // Operand sign bits are the last ones through the cell
                a_msb_q <= x_bit;
                b_msb_q <= y_bit;
            end
        end
    end

    // Result registers: load once on entering DONE, hold until accepted
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else if (publish) begin
            out_valid_q <= 1'b1;
            diff_q      <= res_q;
            bout_q      <= borrow_q;
            // Signed overflow: operands of opposite sign and the result
            // sign differs from the minuend
            ovf_q       <= (a_msb_q != b_msb_q) && (res_q[WIDTH-1] != a_msb_q);
            zero_q      <= (res_q == '0);
        end else if (release_res) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH = 8): directed corner
// cases plus randomized operands against an integer-arithmetic model.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             zero;

    int n_tests = 0;
    int n_fail  = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic
    function automatic int to_signed8(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    // One full transaction: present operands, wait for the result, apply
    // 'hold' cycles of backpressure (pulsing ignored in_valid), then release.
    task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input int hold);
        int lat;
        int wait_cnt;
        int sd;
        logic [7:0] exp_diff;
        logic       exp_bout, exp_ovf, exp_zero;
        logic [7:0] held_diff;

        exp_diff = av - bv;
        exp_bout = (int'(av) < int'(bv));
        sd       = to_signed8(int'(av)) - to_signed8(int'(bv));
        exp_ovf  = (sd > 127) || (sd < -128);
        exp_zero = (exp_diff == 8'h00);

        @(negedge clk);
        a = av;
        b = bv;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        wait_cnt = 0;
        while (!in_ready && wait_cnt < 50) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);          // acceptance edge
        @(negedge clk);
        in_valid = 1'b0;
        // Scramble operands while shifting: must have no effect
        a = 8'($urandom);
        b = 8'($urandom);

        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 3) begin
                in_valid = 1'b1;  // ignored while busy
            end
            if (lat == 5) begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check("latency", 32'(lat), 32'd9);
        if (!out_valid) return;

        check("diff", 32'(diff), 32'(exp_diff));
        check("bout", 32'(bout), 32'(exp_bout));
        check("ovf",  32'(ovf),  32'(exp_ovf));
        check("zero", 32'(zero), 32'(exp_zero));
        held_diff = diff;

        for (int i = 0; i < hold; i++) begin
            a = 8'h01;
            b = 8'h00;
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_diff",  32'(diff), 32'(held_diff));
            check("bp_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);          // result handshake
        @(negedge clk);
        out_ready = 1'b0;
        check("post_ready", 32'(in_ready), 32'd1);
        check("post_valid", 32'(out_valid), 32'd0);
        $display("[TB] op a=0x%02h b=0x%02h hold=%0d -> diff=0x%02h bout=%0d ovf=%0d zero=%0d",
                 av, bv, hold, held_diff, exp_bout, exp_ovf, exp_zero);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset, then idle
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_in_ready",  32'(in_ready), 32'd1);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_diff",      32'(diff), 32'd0);
            check("rst_bout",      32'(bout), 32'd0);
        end
        check("rst_ovf",  32'(ovf), 32'd0);
        check("rst_zero", 32'(zero), 32'd0);

        // Directed corner cases
        do_op(8'h5A, 8'h23, 0);
        do_op(8'h10, 8'h20, 0);
        do_op(8'h77, 8'h77, 0);
        do_op(8'h80, 8'h01, 0);
        do_op(8'h7F, 8'hFF, 0);
        do_op(8'h00, 8'h00, 1);
        do_op(8'h00, 8'hFF, 0);

        // Backpressure with ignored in_valid pulses
        do_op(8'hC3, 8'h3C, 5);
        repeat (3) begin
            @(negedge clk);
            check("idle_after_bp_ready", 32'(in_ready), 32'd1);
            check("idle_after_bp_valid", 32'(out_valid), 32'd0);
        end

        // Reset during the 4th SHIFT cycle
        @(negedge clk);
        a = 8'hFF;
        b = 8'h01;
        in_valid = 1'b1;
        @(posedge clk);          // accepted
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check("midrst_in_ready",  32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_diff",      32'(diff), 32'd0);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 15; i++) begin
                @(negedge clk);
                if (out_valid) seen = 1'b1;
            end
            check("midrst_no_valid", 32'(seen), 32'd0);
        end
        do_op(8'h03, 8'h01, 0);

        // Randomized operands with random backpressure
        for (int i = 0; i < 30; i++) begin
            do_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
